// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: the 3-bit mode
// encoding and a helper that classifies shift/rotate modes.
package shift_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_LOAD = 3'd1;
  localparam mode_t MODE_SHL  = 3'd2;
  localparam mode_t MODE_SHR  = 3'd3;
  localparam mode_t MODE_ROL  = 3'd4;
  localparam mode_t MODE_ROR  = 3'd5;
  localparam mode_t MODE_ASR  = 3'd6;
  // 3'd7 is reserved and decodes as HOLD.

  // True for every mode that moves data by one position (and so counts).
  function automatic logic is_shift_mode(input mode_t m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: control/data inputs and registered outputs.
// The par signal exists only when SHIFT_PARITY_EN is defined.
interface univ_shift_reg_if
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  localparam int CW = $clog2(WIDTH) + 1;

  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic [CW-1:0]    cnt;
  logic             done;
`ifdef SHIFT_PARITY_EN
  logic             par;
`endif

  // Driver side: the parallel datapath / link controller.
  modport master (
    output en, mode, d, sin,
    input  q, sout, cnt, done
`ifdef SHIFT_PARITY_EN
    , input par
`endif
  );

  // Register side.
  modport slave (
    input  en, mode, d, sin,
    output q, sout, cnt, done
`ifdef SHIFT_PARITY_EN
    , output par
`endif
  );

endinterface

// File: rtl/shift_cnt.sv
// Saturating shift counter with a one-cycle done pulse on the edge where
// the count reaches WIDTH. A clear (LOAD) restarts the count.
module shift_cnt #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [CW-1:0] cnt_d, cnt_q;
  logic          done_d, done_q;

  // Next count and done pulse; done fires only on the WIDTH-1 -> WIDTH step.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      if (clr) begin
        cnt_d = '0;
      end else if (inc && (cnt_q != CNT_MAX)) begin
        cnt_d  = cnt_q + 1'b1;
        done_d = (cnt_q == CNT_MAX - 1'b1);
      end
    end
  end

  // Counter state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, logical shifts, rotates
// and arithmetic shift right, with registered serial out and a shift
// counter. Defining SHIFT_PARITY_EN adds a registered even-parity output.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic              clk,
  input logic              reset_n,
  univ_shift_reg_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] q_d, q_q;
  logic             sout_d, sout_q;
  logic [CW-1:0]    cnt;
  logic             done;
`ifdef SHIFT_PARITY_EN
  logic             par_d, par_q;
`endif

  // Mode decode: next register contents and the bit leaving the register.
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    if (bus.en) begin
      case (bus.mode)
        MODE_LOAD: q_d = bus.d;
        MODE_SHL: begin
          q_d    = {q_q[WIDTH-2:0], bus.sin};
          sout_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d    = {bus.sin, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        MODE_ROL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d = q_q[WIDTH-1];
        end
        MODE_ROR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        MODE_ASR: begin
          q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        default: ; // HOLD and the reserved encoding keep everything
      endcase
    end
`ifdef SHIFT_PARITY_EN
    par_d = ^q_d;
`endif
  end

  // Data path registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q    <= RESET_VAL;
      sout_q <= 1'b0;
`ifdef SHIFT_PARITY_EN
      par_q  <= ^RESET_VAL;
`endif
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
`ifdef SHIFT_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  shift_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (bus.en),
    .clr     (bus.mode == MODE_LOAD),
    .inc     (is_shift_mode(bus.mode)),
    .cnt     (cnt),
    .done    (done)
  );

  assign bus.q    = q_q;
  assign bus.sout = sout_q;
  assign bus.cnt  = cnt;
  assign bus.done = done;
`ifdef SHIFT_PARITY_EN
  assign bus.par  = par_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=0): directed
// scenarios plus randomized traffic against an arithmetic reference model.
module tb_univ_shift_reg;
  import shift_pkg::*;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state (plain integers).
  int m_q, m_sout, m_cnt, m_done;

  univ_shift_reg_if #(.WIDTH(WIDTH)) bus ();

  univ_shift_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL ('0)
  ) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: next state computed from the operation rules with arithmetic.
  task automatic model(input logic rn, input logic e, input int m, input int dv, input int s);
    if (!rn) begin
      m_q = 0; m_sout = 0; m_cnt = 0; m_done = 0;
    end else if (!e) begin
      m_done = 0;
    end else begin
      m_done = 0;
      case (m)
        1: begin m_q = dv; m_cnt = 0; end
        2, 3, 4, 5, 6: begin
          case (m)
            2: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + s; end
            3: begin m_sout = m_q % 2;   m_q = m_q / 2 + s * 128; end
            4: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + m_q / 128; end
            5: begin m_sout = m_q % 2;   m_q = m_q / 2 + (m_q % 2) * 128; end
            default: begin m_sout = m_q % 2; m_q = m_q / 2 + (m_q >= 128 ? 128 : 0); end
          endcase
          if (m_cnt == 7) m_done = 1;
          if (m_cnt < 8) m_cnt = m_cnt + 1;
        end
        default: ;
      endcase
    end
  endtask

  // Drive one operation, advance one edge, settle before sampling.
  task automatic step(input logic rn, input logic e, input int m, input int dv, input int s);
    rst_n    = rn;
    bus.en   = e;
    bus.mode = mode_t'(m);
    bus.d    = dv[7:0];
    bus.sin  = s[0];
    model(rn, e, m, dv, s);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, MODE_LOAD, 8'hFF, 0);
    if (bus.q !== 8'h00)   begin $display("FAIL reset_q got=%h want=00", bus.q); n_err++; end
    n_cmp++;
    if (bus.sout !== 1'b0) begin $display("FAIL reset_sout got=%b want=0", bus.sout); n_err++; end
    n_cmp++;
    if (bus.cnt !== 4'd0)  begin $display("FAIL reset_cnt got=%0d want=0", bus.cnt); n_err++; end
    n_cmp++;
    if (bus.done !== 1'b0) begin $display("FAIL reset_done got=%b want=0", bus.done); n_err++; end
    n_cmp++;
  endtask

  task automatic test_load_shift();
    step(1'b1, 1'b1, MODE_LOAD, 8'hA5, 0);
    step(1'b1, 1'b1, MODE_SHL, 0, 0);
    if (bus.q !== 8'h4A || bus.sout !== 1'b1 || bus.cnt !== 4'd1) begin
      $display("FAIL shl got q=%h sout=%b cnt=%0d want q=4a sout=1 cnt=1", bus.q, bus.sout, bus.cnt);
      n_err++;
    end
    n_cmp++;
    step(1'b1, 1'b1, MODE_SHR, 0, 1);
    if (bus.q !== 8'hA5 || bus.sout !== 1'b0 || bus.cnt !== 4'd2) begin
      $display("FAIL shr got q=%h sout=%b cnt=%0d want q=a5 sout=0 cnt=2", bus.q, bus.sout, bus.cnt);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_rotate_asr();
    step(1'b1, 1'b1, MODE_LOAD, 8'h81, 0);
    step(1'b1, 1'b1, MODE_ROR, 0, 0);
    if (bus.q !== 8'hC0 || bus.sout !== 1'b1) begin
      $display("FAIL ror got q=%h sout=%b want q=c0 sout=1", bus.q, bus.sout); n_err++;
    end
    n_cmp++;
    step(1'b1, 1'b1, MODE_LOAD, 8'h80, 0);
    step(1'b1, 1'b1, MODE_ASR, 0, 1);
    if (bus.q !== 8'hC0 || bus.sout !== 1'b0) begin
      $display("FAIL asr got q=%h sout=%b want q=c0 sout=0", bus.q, bus.sout); n_err++;
    end
    n_cmp++;
    step(1'b1, 1'b1, 7, 8'h55, 1);
    if (bus.q !== 8'hC0 || bus.cnt !== 4'd1) begin
      $display("FAIL reserved_hold got q=%h cnt=%0d want q=c0 cnt=1", bus.q, bus.cnt); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b1, MODE_LOAD, 8'h00, 0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, MODE_SHR, 0, 1);
    if (bus.done !== 1'b0 || bus.cnt !== 4'd7) begin
      $display("FAIL pre_done got done=%b cnt=%0d want done=0 cnt=7", bus.done, bus.cnt); n_err++;
    end
    n_cmp++;
    step(1'b1, 1'b1, MODE_SHR, 0, 1);
    if (bus.q !== 8'hFF || bus.cnt !== 4'd8 || bus.done !== 1'b1) begin
      $display("FAIL done_pulse got q=%h cnt=%0d done=%b want q=ff cnt=8 done=1", bus.q, bus.cnt, bus.done);
      n_err++;
    end
    n_cmp++;
    step(1'b1, 1'b1, MODE_SHR, 0, 0);
    if (bus.q !== 8'h7F || bus.cnt !== 4'd8 || bus.done !== 1'b0) begin
      $display("FAIL saturate got q=%h cnt=%0d done=%b want q=7f cnt=8 done=0", bus.q, bus.cnt, bus.done);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_enable();
    step(1'b1, 1'b1, MODE_LOAD, 8'h3C, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, MODE_SHL, 0, 1);
      if (bus.q !== 8'h3C || bus.cnt !== 4'd0 || bus.done !== 1'b0) begin
        $display("FAIL en_low got q=%h cnt=%0d done=%b want q=3c cnt=0 done=0", bus.q, bus.cnt, bus.done);
        n_err++;
      end
      n_cmp++;
    end
    step(1'b1, 1'b1, MODE_SHL, 0, 0);
    if (bus.q !== 8'h78 || bus.cnt !== 4'd1) begin
      $display("FAIL en_resume got q=%h cnt=%0d want q=78 cnt=1", bus.q, bus.cnt); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, MODE_LOAD, 8'h5A, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, MODE_ROL, 0, 0);
    if (bus.cnt !== 4'd5) begin
      $display("FAIL mid_cnt got=%0d want=5", bus.cnt); n_err++;
    end
    n_cmp++;
    step(1'b0, 1'b1, MODE_ROL, 0, 0);
    if (bus.q !== 8'h00 || bus.cnt !== 4'd0 || bus.done !== 1'b0) begin
      $display("FAIL mid_reset got q=%h cnt=%0d done=%b want q=00 cnt=0 done=0", bus.q, bus.cnt, bus.done);
      n_err++;
    end
    n_cmp++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, MODE_SHL, 0, 1);
      if (bus.done !== 1'b0) begin
        $display("FAIL mid_no_done got=%b want=0", bus.done); n_err++;
      end
      n_cmp++;
    end
`ifdef SHIFT_PARITY_EN
    step(1'b1, 1'b1, MODE_LOAD, 8'h07, 0);
    if (bus.par !== 1'b1) begin
      $display("FAIL parity_07 got=%b want=1", bus.par); n_err++;
    end
    n_cmp++;
`endif
  endtask

  task automatic test_random();
    int m;
    step(1'b0, 1'b0, MODE_HOLD, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) m = MODE_LOAD;
      else begin
        m = int'($urandom_range(6));
        if (m == MODE_LOAD) m = 7;
      end
      step(($urandom_range(39) != 0), ($urandom_range(3) != 0), m,
           int'($urandom_range(255)), int'($urandom_range(1)));
      if (bus.q !== m_q[7:0] || bus.sout !== m_sout[0] ||
          bus.cnt !== m_cnt[3:0] || bus.done !== m_done[0]) begin
        $display("FAIL random[%0d] got q=%h sout=%b cnt=%0d done=%b want q=%h sout=%0d cnt=%0d done=%0d",
                 i, bus.q, bus.sout, bus.cnt, bus.done, m_q[7:0], m_sout, m_cnt, m_done);
        n_err++;
      end
      n_cmp++;
`ifdef SHIFT_PARITY_EN
      if (bus.par !== 1'($countones(m_q[7:0]) % 2)) begin
        $display("FAIL random_par[%0d] got=%b want=%0d", i, bus.par, $countones(m_q[7:0]) % 2);
        n_err++;
      end
      n_cmp++;
`endif
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.mode = MODE_HOLD;
    bus.d    = '0;
    bus.sin  = 1'b0;
    m_q = 0; m_sout = 0; m_cnt = 0; m_done = 0;
    @(negedge clk);
    test_reset();
    test_load_shift();
    test_rotate_asr();
    test_saturation();
    test_enable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
